// File: rtl/test_result_monitor_pkg.sv
// Shared definitions for the test result monitor: FSM state encoding,
// default register indices and a register-write decode helper.
package test_result_monitor_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_e;

    localparam int DEF_DONE_REG    = 26;
    localparam int DEF_PASS_REG    = 27;
    localparam int DEF_TNUM_REG    = 3;
    localparam int DEF_CONSOLE_REG = 15;

    // True when a regfile write targets idx; x0 never matches.
    function automatic logic reg_hit(input logic we, input logic [4:0] addr,
                                     input logic [4:0] idx);
        return we && (addr != 5'd0) && (addr == idx);
    endfunction

endpackage

// File: rtl/test_result_monitor_fifo.sv
// Small synchronous FIFO for console characters. Pointers carry one extra
// wrap bit so full/empty are distinguished without a counter. Head data is
// read straight from storage, so a push into an empty FIFO shows up one
// edge later (no fall-through).
module test_result_monitor_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; clear wins over any same-edge push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write, no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear_i) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/test_result_monitor.sv
// Observational riscv-tests verdict monitor. Snoops the regfile write port,
// shadows the pass flag and test number, and decides PASS/FAIL/TIMEOUT with
// a fixed settle delay after the done write.
// Optional console FIFO is built when MON_CONSOLE_EN is defined.
module test_result_monitor
    import test_result_monitor_pkg::*;
#(
    parameter int DONE_REG    = DEF_DONE_REG,
    parameter int PASS_REG    = DEF_PASS_REG,
    parameter int TNUM_REG    = DEF_TNUM_REG,
    parameter int CONSOLE_REG = DEF_CONSOLE_REG,
    parameter int SETTLE_CYC  = 20,
    parameter int MAX_CYC     = 100000,
    parameter int CYC_W       = 32,
    parameter int CON_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [4:0]       waddr_i,
    input  logic [31:0]      wdata_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [31:0]      testnum_o,
    output logic [CYC_W-1:0] cycles_o,
    output logic             con_valid_o,
    output logic [7:0]       con_data_o,
    input  logic             con_ready_i,
    output logic             con_ovf_o
);
    localparam int SC_W = $clog2(SETTLE_CYC + 1);
    // settle count is 0 on the first SETTLE edge, so matching SETTLE_CYC puts
    // the verdict edge SETTLE_CYC+1 edges after the done write.
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYC);
    localparam logic [CYC_W-1:0] MAX_M1      = CYC_W'(MAX_CYC - 1);

    mon_state_e       r_state;
    logic [31:0]      r_pass_sh;
    logic [31:0]      r_tnum;
    logic [CYC_W-1:0] r_cycles;
    logic [SC_W-1:0]  r_settle_cnt;
    logic             r_done, r_pass, r_fail, r_timeout;

    logic             w_done_wr, w_pass_wr, w_tnum_wr;
    logic [31:0]      w_pass_val;

    assign w_done_wr  = reg_hit(we_i, waddr_i, 5'(DONE_REG)) && (wdata_i == 32'd1);
    assign w_pass_wr  = reg_hit(we_i, waddr_i, 5'(PASS_REG));
    assign w_tnum_wr  = reg_hit(we_i, waddr_i, 5'(TNUM_REG));
    // A pass-flag write on the verdict edge itself must count.
    assign w_pass_val = w_pass_wr ? wdata_i : r_pass_sh;

    assign done_o    = r_done;
    assign pass_o    = r_pass;
    assign fail_o    = r_fail;
    assign timeout_o = r_timeout;
    assign testnum_o = r_tnum;
    assign cycles_o  = r_cycles;

    // Verdict FSM with shadows, saturating RUN counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pass_sh    <= '0;
            r_tnum       <= '0;
            r_cycles     <= '0;
            r_settle_cnt <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (clear_i) begin
            r_state      <= ST_RUN;
            r_pass_sh    <= '0;
            r_tnum       <= '0;
            r_cycles     <= '0;
            r_settle_cnt <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            // Shadows stop once a verdict is taken so testnum_o stays frozen.
            if (r_state == ST_RUN || r_state == ST_SETTLE) begin
                if (w_pass_wr) r_pass_sh <= wdata_i;
                if (w_tnum_wr) r_tnum    <= wdata_i;
            end
            case (r_state)
                ST_RUN: begin
                    if (r_cycles != '1) r_cycles <= r_cycles + CYC_W'(1);
                    if (w_done_wr) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end else if (r_cycles == MAX_M1) begin
                        r_state   <= ST_TIMEOUT;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + SC_W'(1);
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_done <= 1'b1;
                        if (w_pass_val == 32'd1) begin
                            r_state <= ST_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MON_CONSOLE_EN
    logic       w_con_wr, w_full, w_empty, w_pop;
    logic [7:0] w_head;
    logic       r_ovf;

    assign w_con_wr    = reg_hit(we_i, waddr_i, 5'(CONSOLE_REG));
    assign w_pop       = con_ready_i && !w_empty;
    assign con_valid_o = !w_empty;
    assign con_data_o  = w_head;
    assign con_ovf_o   = r_ovf;

    test_result_monitor_fifo #(.WIDTH(8), .DEPTH(CON_DEPTH)) u_con_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .push_i  (w_con_wr),
        .pop_i   (con_ready_i),
        .data_i  (wdata_i[7:0]),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Sticky overflow: a char arrived on a full FIFO with nothing leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_ovf <= 1'b0;
        else if (clear_i)                       r_ovf <= 1'b0;
        else if (w_con_wr && w_full && !w_pop)  r_ovf <= 1'b1;
    end
`else
    logic w_unused;
    assign w_unused    = ^{con_ready_i, CONSOLE_REG, CON_DEPTH};
    assign con_valid_o = 1'b0;
    assign con_data_o  = 8'd0;
    assign con_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_test_result_monitor.sv
// Self-checking bench for test_result_monitor (SETTLE_CYC=4, MAX_CYC=64,
// CON_DEPTH=4). Verdicts go through a scoreboard queue checked on done_o rise.
module tb_test_result_monitor;
    localparam int CYC_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clear_i = 1'b0;
    logic             we_i = 1'b0;
    logic [4:0]       waddr_i = '0;
    logic [31:0]      wdata_i = '0;
    logic             con_ready_i = 1'b0;
    logic             done_o, pass_o, fail_o, timeout_o, con_valid_o, con_ovf_o;
    logic [31:0]      testnum_o;
    logic [CYC_W-1:0] cycles_o;
    logic [7:0]       con_data_o;

    test_result_monitor #(
        .SETTLE_CYC(4), .MAX_CYC(64), .CYC_W(CYC_W), .CON_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
        .timeout_o(timeout_o), .testnum_o(testnum_o), .cycles_o(cycles_o),
        .con_valid_o(con_valid_o), .con_data_o(con_data_o),
        .con_ready_i(con_ready_i), .con_ovf_o(con_ovf_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int edges;

    typedef struct {
        logic        p, f, t;
        logic [31:0] tnum;
        int          at_edge;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] tnum, passv;
        logic        late_en;
        logic [4:0]  late_a;
        logic [31:0] late_d;
        int          late_off;
        logic        exp_p;
        logic [31:0] exp_tnum;
    } vec_t;
    vec_t vecs[7];

    // Edge number since reset release, stable when read at negedge.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Verdict checker: every done_o rise must match the oldest expectation.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) prev_done = 1'b0;
        else begin
            if (done_o && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pass_o",    pass_o,    e.p);
                    chk("fail_o",    fail_o,    e.f);
                    chk("timeout_o", timeout_o, e.t);
                    chk("testnum_o", testnum_o, e.tnum);
                    chk("done_edge", edges,     e.at_edge);
                end
            end
            prev_done = done_o;
        end
    end

    // All drivers below are called at a negedge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        @(negedge clk);
        we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_sb(input string nm);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: verdict not seen, %0d pending, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int n;
        logic [7:0] msg [5];
        logic [7:0] cq[$];
        logic       exp_ovf;

        //            tnum      passv   late  addr  data  off  pass tnum
        vecs[0] = '{32'd1,     32'd1, 1'b0, 5'd0,  32'd0, 0, 1'b1, 32'd1};
        vecs[1] = '{32'd7,     32'd0, 1'b0, 5'd0,  32'd0, 0, 1'b0, 32'd7};
        vecs[2] = '{32'd7,     32'd0, 1'b1, 5'd3,  32'd9, 2, 1'b0, 32'd9};
        vecs[3] = '{32'd5,     32'd0, 1'b1, 5'd27, 32'd1, 5, 1'b1, 32'd5};
        vecs[4] = '{32'd2,     32'd2, 1'b0, 5'd0,  32'd0, 0, 1'b0, 32'd2};
        vecs[5] = '{32'hBEEF,  32'd0, 1'b1, 5'd27, 32'd1, 6, 1'b0, 32'hBEEF};
        vecs[6] = '{32'd4,     32'd1, 1'b1, 5'd26, 32'd1, 3, 1'b1, 32'd4};

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        chk("rst_done", done_o, 0);     chk("rst_pass", pass_o, 0);
        chk("rst_fail", fail_o, 0);     chk("rst_tout", timeout_o, 0);
        chk("rst_tnum", testnum_o, 0);  chk("rst_cyc", cycles_o, 0);
        chk("rst_cval", con_valid_o, 0); chk("rst_ovf", con_ovf_o, 0);
        rst = 1'b0;

        // Timeout at edge 64 with no done write
        sb.push_back('{1'b0, 1'b0, 1'b1, 32'd0, 64});
        while (edges < 63) @(negedge clk);
        chk("tout_e63", timeout_o, 0);
        chk("cyc_e63", cycles_o, 63);
        @(negedge clk);
        chk("tout_e64", timeout_o, 1);
        chk("cyc_e64", cycles_o, 64);
        wait_sb("timeout");
        wr(5'd26, 32'd1);
        repeat (6) @(negedge clk);
        chk("tout_hold", timeout_o, 1);
        chk("tout_nopass", pass_o, 0);
        chk("cyc_frozen", cycles_o, 64);

        // Done write on edge 64 beats timeout; x0 write ignored
        do_reset();
        wr(5'd0, 32'd1);
        chk("x0_nodone", done_o, 0);
        while (edges < 63) @(negedge clk);
        wr(5'd26, 32'd1);
        n = edges;
        sb.push_back('{1'b0, 1'b1, 1'b0, 32'd0, n + 5});
        chk("done64_notout", timeout_o, 0);
        wait_sb("done64");
        chk("done64_cyc", cycles_o, 64);

        // Table-driven verdict vectors
        for (int i = 0; i < 7; i++) begin
            do_clear();
            wr(5'd3, vecs[i].tnum);
            wr(5'd27, vecs[i].passv);
            wr(5'd26, 32'd1);
            n = edges;
            sb.push_back('{vecs[i].exp_p, !vecs[i].exp_p, 1'b0, vecs[i].exp_tnum, n + 5});
            if (vecs[i].late_en) begin
                repeat (vecs[i].late_off - 1) @(negedge clk);
                wr(vecs[i].late_a, vecs[i].late_d);
            end
            wait_sb($sformatf("vec%0d", i));
        end

        // clear in PASS
        do_clear();
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        n = edges;
        sb.push_back('{1'b1, 1'b0, 1'b0, 32'd0, n + 5});
        wait_sb("pass_then_clear");
        do_clear();
        chk("clr_done", done_o, 0);  chk("clr_pass", pass_o, 0);
        chk("clr_cyc", cycles_o, 0); chk("clr_tnum", testnum_o, 0);

        // Writes on the clear edge are dropped
        clear_i = 1'b1; we_i = 1'b1; waddr_i = 5'd26; wdata_i = 32'd1;
        @(negedge clk);
        clear_i = 1'b0; we_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("clr_done_dropped", done_o, 0);
        clear_i = 1'b1; we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h55;
        @(negedge clk);
        clear_i = 1'b0; we_i = 1'b0;
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        n = edges;
        sb.push_back('{1'b1, 1'b0, 1'b0, 32'd0, n + 5});
        wait_sb("clr_tnum_dropped");

        // Asynchronous reset in the middle of SETTLE
        do_clear();
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_cyc", cycles_o, 0);
        chk("arst_done", done_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("arst_no_verdict", done_o, 0);

`ifdef MON_CONSOLE_EN
        msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h21; msg[3] = 8'h0a; msg[4] = 8'h58;
        exp_ovf = 1'b0;
        chk("con_empty", con_valid_o, 0);
        for (int i = 0; i < 5; i++) begin
            wr(5'd15, {24'd0, msg[i]});
            if (cq.size() < 4) cq.push_back(msg[i]);
            else               exp_ovf = 1'b1;
            if (i == 0) chk("con_first_valid", con_valid_o, 1);
        end
        chk("con_ovf", con_ovf_o, exp_ovf);
        while (cq.size() > 0) begin
            chk("con_valid", con_valid_o, 1);
            chk("con_data", con_data_o, cq.pop_front());
            con_ready_i = 1'b1;
            @(negedge clk);
            con_ready_i = 1'b0;
        end
        chk("con_drained", con_valid_o, 0);
        do_clear();
        chk("con_ovf_clr", con_ovf_o, 0);
        for (int i = 0; i < 4; i++) begin
            wr(5'd15, 32'h61 + i);
            cq.push_back(8'h61 + 8'(i));
        end
        con_ready_i = 1'b1;
        wr(5'd15, 32'h65);
        con_ready_i = 1'b0;
        void'(cq.pop_front());
        cq.push_back(8'h65);
        chk("con_full_pop_noovf", con_ovf_o, 0);
        while (cq.size() > 0) begin
            chk("con_data2", con_data_o, cq.pop_front());
            con_ready_i = 1'b1;
            @(negedge clk);
            con_ready_i = 1'b0;
        end
        chk("con_drained2", con_valid_o, 0);
`else
        wr(5'd15, 32'h48);
        chk("con_off_valid", con_valid_o, 0);
        chk("con_off_data", con_data_o, 0);
        chk("con_off_ovf", con_ovf_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, pending=%0d expected 0", sb.size());
        $fatal(1);
    end

endmodule
